// File: rtl/mem_arbiter_unit_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, word type and FSM state codes.
package mem_arbiter_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RS_FREE   = 2'd0,
        RS_BUSY   = 2'd1,
        RS_ACCESS = 2'd2,
        RS_ERROR  = 2'd3
    } ramstate_t;

    // Plain codes rather than an enum so legacy netlists and scripts keep matching.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_DSERV = 2'd1;
    localparam arb_state_t ST_ISERV = 2'd2;
    localparam arb_state_t ST_HIT   = 2'd3;

endpackage

// File: rtl/mem_arbiter_unit_if.sv
// Bundles the pipeline-side request/response signals and the RAM-side port of the arbiter.
interface mem_arbiter_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arbiter_unit_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              bus_err;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    // The master side is the environment: the pipeline requesters plus the RAM model.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, bus_err, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, bus_err, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_unit.sv
// Single-port RAM arbiter: data requests win over fetch, one-cycle hit pulses, wait timeout with bus_err.
module mem_arbiter_unit
    import mem_arbiter_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic              CLK,
    input logic              nRST,
    mem_arbiter_unit_if.slave bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_data_q, gnt_data_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] iload_q, dload_q;

    logic              d_req;
    logic              access;
    logic              serving;
    logic              cap_i, cap_d;
    logic              ram_ren, ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;

    assign d_req  = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RS_ACCESS);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = '0;
        gnt_data_d = gnt_data_q;
        bus_err_d  = 1'b0;
        serving    = 1'b0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;

        case (state_q)
            ST_IDLE: begin
                if (d_req)         state_d = ST_DSERV;
                else if (bus.iREN) state_d = ST_ISERV;
            end
            ST_DSERV: begin
                if (d_req) begin
                    serving  = 1'b1;
                    ram_addr = bus.daddr;
                    if (bus.dWEN) begin
                        ram_wen   = 1'b1;
                        ram_store = bus.dstore;
                    end else begin
                        ram_ren = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISERV: begin
                if (bus.iREN) begin
                    serving  = 1'b1;
                    ram_ren  = 1'b1;
                    ram_addr = bus.iaddr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A withdrawn request never reaches here, so an abort leaves the counter cleared.
        if (serving) begin
            if (access) begin
                state_d    = ST_HIT;
                gnt_data_d = (state_q == ST_DSERV);
            end else if (cnt_q == CNT_LAST) begin
                state_d   = ST_IDLE;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stores complete with a dhit but leave dload untouched.
    assign cap_d = serving && access && ram_ren && (state_q == ST_DSERV);
    assign cap_i = serving && access && (state_q == ST_ISERV);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_data_q <= 1'b0;
            bus_err_q  <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_data_q <= gnt_data_d;
            bus_err_q  <= bus_err_d;
            if (cap_i) iload_q <= bus.ramload;
            if (cap_d) dload_q <= bus.ramload;
        end
    end

    assign bus.ihit     = (state_q == ST_HIT) && !gnt_data_q;
    assign bus.dhit     = (state_q == ST_HIT) &&  gnt_data_q;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;

endmodule
